// File: rtl/wb_req_flit_gen_pkg.sv
// Shared types and constants for the writeback-request flit generator.
// Header field offsets are the LSB positions inside a 64-bit flit.
package wb_req_flit_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_HDR2 = 3'd3,
        ST_DATA = 3'd4
    } state_t;

    localparam logic [7:0] MSG_TYPE_WB_REQ    = 8'd12;
    localparam logic [7:0] WB_REQ_PAYLOAD_LEN = 8'd3;

    localparam int CHIPID_LSB = 50;
    localparam int XPOS_LSB   = 42;
    localparam int YPOS_LSB   = 34;
    localparam int FBITS_LSB  = 30;
    localparam int LEN_LSB    = 22;
    localparam int TYPE_LSB   = 14;
    localparam int MSHR_LSB   = 6;
    localparam int ADDR_LSB   = 24;

endpackage

// File: rtl/wb_req_flit_fmt.sv
// Combinational flit formatter: selects the flit for the current state
// from the captured request fields; all-zero when idle.
module wb_req_flit_fmt
    import wb_req_flit_gen_pkg::*;
#(
    parameter logic [7:0] MSHR_ID = 8'd0,
    parameter logic [3:0] FBITS   = 4'd0
) (
    input  state_t      state,
    input  logic [13:0] chipid,
    input  logic [7:0]  coreid_x,
    input  logic [7:0]  coreid_y,
    input  logic [25:0] tag,
    input  logic [5:0]  source,
    input  logic [63:0] data,
    output logic [63:0] noc3_data_out
);

    always_comb begin
        noc3_data_out = '0;
        case (state)
            ST_HDR0: begin
                noc3_data_out[CHIPID_LSB +: 14] = chipid;
                noc3_data_out[XPOS_LSB   +: 8]  = coreid_x;
                noc3_data_out[YPOS_LSB   +: 8]  = coreid_y;
                noc3_data_out[FBITS_LSB  +: 4]  = FBITS;
                noc3_data_out[LEN_LSB    +: 8]  = WB_REQ_PAYLOAD_LEN;
                noc3_data_out[TYPE_LSB   +: 8]  = MSG_TYPE_WB_REQ;
                noc3_data_out[MSHR_LSB   +: 8]  = MSHR_ID;
            end
            ST_HDR1: begin
                noc3_data_out[ADDR_LSB +: 40] = {tag, 14'd0};
            end
            ST_HDR2: begin
                // Source L1 id is split into a tile x/y pair for the return path.
                noc3_data_out[CHIPID_LSB +: 14] = chipid;
                noc3_data_out[XPOS_LSB   +: 8]  = {5'b0, source[2:0]};
                noc3_data_out[YPOS_LSB   +: 8]  = {5'b0, source[5:3]};
                noc3_data_out[FBITS_LSB  +: 4]  = FBITS;
            end
            ST_DATA: begin
                noc3_data_out = data;
            end
            default: noc3_data_out = '0;
        endcase
    end

endmodule

// File: rtl/wb_req_flit_gen.sv
// Writeback request packetiser: captures a request and emits a 4-flit
// NoC3 packet (3 headers + data), counting completed packets.
module wb_req_flit_gen
    import wb_req_flit_gen_pkg::*;
#(
    parameter logic [7:0] MSHR_ID = 8'd0,
    parameter logic [3:0] FBITS   = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] chipid,
    input  logic [7:0]  coreid_x,
    input  logic [7:0]  coreid_y,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [25:0] req_tag,
    input  logic [5:0]  req_source,
    input  logic [63:0] req_data,
    output logic        noc3_valid_out,
    input  logic        noc3_ready_in,
    output logic [63:0] noc3_data_out,
    output logic [15:0] pkt_cnt,
    output logic        busy
);

    state_t      state;
    logic [13:0] chipid_q;
    logic [7:0]  coreid_x_q;
    logic [7:0]  coreid_y_q;
    logic [25:0] tag_q;
    logic [5:0]  source_q;
    logic [63:0] data_q;
    logic [15:0] pkt_cnt_q;
    logic        accept;
    logic        flit_fire;

    // Ready in DATA only when the last flit leaves, so the next HDR0 follows without a bubble.
    assign req_ready      = (state == ST_IDLE) || ((state == ST_DATA) && noc3_ready_in);
    assign accept         = req_valid && req_ready;
    assign noc3_valid_out = (state != ST_IDLE);
    assign busy           = (state != ST_IDLE);
    assign flit_fire      = noc3_valid_out && noc3_ready_in;
    assign pkt_cnt        = pkt_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            chipid_q   <= '0;
            coreid_x_q <= '0;
            coreid_y_q <= '0;
            tag_q      <= '0;
            source_q   <= '0;
            data_q     <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (accept) begin
                chipid_q   <= chipid;
                coreid_x_q <= coreid_x;
                coreid_y_q <= coreid_y;
                tag_q      <= req_tag;
                source_q   <= req_source;
                data_q     <= req_data;
            end
            case (state)
                ST_IDLE: if (accept)    state <= ST_HDR0;
                ST_HDR0: if (flit_fire) state <= ST_HDR1;
                ST_HDR1: if (flit_fire) state <= ST_HDR2;
                ST_HDR2: if (flit_fire) state <= ST_DATA;
                ST_DATA: begin
                    if (flit_fire) begin
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        state     <= accept ? ST_HDR0 : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_req_flit_fmt #(
        .MSHR_ID (MSHR_ID),
        .FBITS   (FBITS)
    ) u_fmt (
        .state         (state),
        .chipid        (chipid_q),
        .coreid_x      (coreid_x_q),
        .coreid_y      (coreid_y_q),
        .tag           (tag_q),
        .source        (source_q),
        .data          (data_q),
        .noc3_data_out (noc3_data_out)
    );

endmodule

// File: tb/tb_wb_req_flit_gen.sv
// Self-checking bench for wb_req_flit_gen: directed scenarios plus a
// randomized run scored against a queue-based packet model.
module tb_wb_req_flit_gen;

    localparam logic [7:0] P_MSHR  = 8'hA5;
    localparam logic [3:0] P_FBITS = 4'h9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] chipid = '0;
    logic [7:0]  coreid_x = '0;
    logic [7:0]  coreid_y = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [25:0] req_tag = '0;
    logic [5:0]  req_source = '0;
    logic [63:0] req_data = '0;
    logic        noc3_valid_out;
    logic        noc3_ready_in = 1'b1;
    logic [63:0] noc3_data_out;
    logic [15:0] pkt_cnt;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;

    wb_req_flit_gen #(.MSHR_ID(P_MSHR), .FBITS(P_FBITS)) dut (
        .clk            (clk),
        .rst            (rst),
        .chipid         (chipid),
        .coreid_x       (coreid_x),
        .coreid_y       (coreid_y),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_tag        (req_tag),
        .req_source     (req_source),
        .req_data       (req_data),
        .noc3_valid_out (noc3_valid_out),
        .noc3_ready_in  (noc3_ready_in),
        .noc3_data_out  (noc3_data_out),
        .pkt_cnt        (pkt_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected flit k of a packet, built with shifts from the field positions.
    function automatic logic [63:0] exp_flit(input int k, input logic [13:0] c, input logic [7:0] x,
                                             input logic [7:0] y, input logic [25:0] t,
                                             input logic [5:0] s, input logic [63:0] d);
        logic [63:0] f;
        f = 64'd0;
        case (k)
            0: f = (64'(c) << 50) | (64'(x) << 42) | (64'(y) << 34) | (64'(P_FBITS) << 30)
                 | (64'd3 << 22) | (64'd12 << 14) | (64'(P_MSHR) << 6);
            1: f = 64'(t) << 38;
            2: f = (64'(c) << 50) | (64'(s % 8) << 42) | (64'(s / 8) << 34) | (64'(P_FBITS) << 30);
            default: f = d;
        endcase
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [13:0] c, input logic [7:0] x, input logic [7:0] y,
                           input logic [25:0] t, input logic [5:0] s, input logic [63:0] d);
        chipid = c; coreid_x = x; coreid_y = y; req_tag = t; req_source = s; req_data = d;
    endtask

    task automatic set_rand_req;
        set_req(14'($urandom), 8'($urandom), 8'($urandom), 26'($urandom), 6'($urandom),
                {$urandom, $urandom});
    endtask

    task automatic test_reset;
        logic [63:0] e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (noc3_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", noc3_valid_out); end
        checks++; if (noc3_data_out !== 64'd0) begin errors++; $display("FAIL rst_data got %h want 0", noc3_data_out); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %h want 0", pkt_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        rst = 1'b0;
        set_req(14'h1234, 8'h11, 8'h22, 26'h1555555, 6'h15, 64'h0123456789ABCDEF);
        req_valid = 1'b1;
        noc3_ready_in = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_flit(k, 14'h1234, 8'h11, 8'h22, 26'h1555555, 6'h15, 64'h0123456789ABCDEF);
            checks++; if (noc3_valid_out !== 1'b1 || noc3_data_out !== e) begin
                errors++; $display("FAIL first_accept_flit%0d got %b/%h want 1/%h", k, noc3_valid_out, noc3_data_out, e);
            end
            tick;
        end
        exp_cnt++;
        @(negedge clk);
        checks++; if (pkt_cnt !== exp_cnt) begin errors++; $display("FAIL first_cnt got %h want %h", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_single;
        logic [63:0] e;
        tick;
        set_req(14'd1, 8'd2, 8'd3, 26'h2AAAAAA, 6'h2D, 64'hDEADBEEF);
        req_valid = 1'b1;
        noc3_ready_in = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0;
        set_rand_req;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_flit(k, 14'd1, 8'd2, 8'd3, 26'h2AAAAAA, 6'h2D, 64'hDEADBEEF);
            checks++; if (noc3_valid_out !== 1'b1 || noc3_data_out !== e) begin
                errors++; $display("FAIL single_flit%0d got %b/%h want 1/%h", k, noc3_valid_out, noc3_data_out, e);
            end
            if (k == 1) begin
                checks++; if (noc3_data_out[63:24] !== 40'hAAAAAA8000) begin
                    errors++; $display("FAIL single_addr got %h want aaaaaa8000", noc3_data_out[63:24]);
                end
            end
            if (k == 2) begin
                checks++; if (noc3_data_out[49:42] !== 8'h05 || noc3_data_out[41:34] !== 8'h05) begin
                    errors++; $display("FAIL single_srcxy got %h/%h want 05/05", noc3_data_out[49:42], noc3_data_out[41:34]);
                end
            end
            tick;
        end
        exp_cnt++;
        @(negedge clk);
        checks++; if (pkt_cnt !== exp_cnt) begin errors++; $display("FAIL single_cnt got %h want %h", pkt_cnt, exp_cnt); end
        checks++; if (noc3_valid_out !== 1'b0 || noc3_data_out !== 64'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle got %b/%h/%b want 0/0/0", noc3_valid_out, noc3_data_out, busy);
        end
    endtask

    task automatic test_input_change;
        logic [63:0] e;
        tick;
        set_req(14'h2F0F, 8'h7E, 8'h81, 26'h0C0FFEE, 6'h3A, 64'h1122334455667788);
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(14'h0, 8'h0, 8'h0, 26'h0, 6'h0, ~64'h1122334455667788);
            @(negedge clk);
            e = exp_flit(k, 14'h2F0F, 8'h7E, 8'h81, 26'h0C0FFEE, 6'h3A, 64'h1122334455667788);
            checks++; if (noc3_data_out !== e) begin
                errors++; $display("FAIL chg_flit%0d got %h want %h", k, noc3_data_out, e);
            end
            tick;
        end
        exp_cnt++;
    endtask

    task automatic test_backpressure;
        logic [63:0] e;
        int          k;
        tick;
        set_req(14'h0ABC, 8'h33, 8'h44, 26'h3FFFFFF, 6'h07, 64'hCAFEF00DCAFEF00D);
        req_valid = 1'b1;
        noc3_ready_in = 1'b1;
        tick;
        req_valid = 1'b0;
        @(negedge clk);
        e = exp_flit(0, 14'h0ABC, 8'h33, 8'h44, 26'h3FFFFFF, 6'h07, 64'hCAFEF00DCAFEF00D);
        checks++; if (noc3_data_out !== e) begin errors++; $display("FAIL bp_flit0 got %h want %h", noc3_data_out, e); end
        tick;
        noc3_ready_in = 1'b0;
        e = exp_flit(1, 14'h0ABC, 8'h33, 8'h44, 26'h3FFFFFF, 6'h07, 64'hCAFEF00DCAFEF00D);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (noc3_valid_out !== 1'b1 || noc3_data_out !== e || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got %b/%h/%b want 1/%h/0", c, noc3_valid_out, noc3_data_out, req_ready, e);
            end
            tick;
        end
        noc3_ready_in = 1'b1;
        for (k = 1; k < 4; k++) begin
            @(negedge clk);
            e = exp_flit(k, 14'h0ABC, 8'h33, 8'h44, 26'h3FFFFFF, 6'h07, 64'hCAFEF00DCAFEF00D);
            checks++; if (noc3_valid_out !== 1'b1 || noc3_data_out !== e) begin
                errors++; $display("FAIL bp_flit%0d got %b/%h want 1/%h", k, noc3_valid_out, noc3_data_out, e);
            end
            tick;
        end
        exp_cnt++;
        @(negedge clk);
        checks++; if (noc3_valid_out !== 1'b0 || pkt_cnt !== exp_cnt) begin
            errors++; $display("FAIL bp_done got %b/%h want 0/%h", noc3_valid_out, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] e;
        tick;
        set_req(14'h0101, 8'h01, 8'h02, 26'h0000001, 6'h01, 64'hAAAA0000AAAA0000);
        req_valid = 1'b1;
        noc3_ready_in = 1'b1;
        tick;
        set_req(14'h0202, 8'h03, 8'h04, 26'h0000002, 6'h3E, 64'h5555FFFF5555FFFF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < 4) e = exp_flit(k, 14'h0101, 8'h01, 8'h02, 26'h0000001, 6'h01, 64'hAAAA0000AAAA0000);
            else       e = exp_flit(k - 4, 14'h0202, 8'h03, 8'h04, 26'h0000002, 6'h3E, 64'h5555FFFF5555FFFF);
            checks++; if (noc3_valid_out !== 1'b1 || noc3_data_out !== e) begin
                errors++; $display("FAIL b2b_flit%0d got %b/%h want 1/%h", k, noc3_valid_out, noc3_data_out, e);
            end
            if (k < 4) begin
                checks++; if (req_ready !== (k == 3)) begin
                    errors++; $display("FAIL b2b_ready%0d got %b want %b", k, req_ready, (k == 3));
                end
            end
            tick;
            if (k == 3) req_valid = 1'b0;
        end
        exp_cnt = exp_cnt + 16'd2;
        @(negedge clk);
        checks++; if (noc3_valid_out !== 1'b0 || pkt_cnt !== exp_cnt) begin
            errors++; $display("FAIL b2b_done got %b/%h want 0/%h", noc3_valid_out, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] e;
        tick;
        set_req(14'h3333, 8'h55, 8'h66, 26'h1234567, 6'h12, 64'h0F0F0F0F0F0F0F0F);
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        @(negedge clk);
        e = exp_flit(2, 14'h3333, 8'h55, 8'h66, 26'h1234567, 6'h12, 64'h0F0F0F0F0F0F0F0F);
        checks++; if (noc3_data_out !== e) begin errors++; $display("FAIL rmid_hdr2 got %h want %h", noc3_data_out, e); end
        #1 rst = 1'b1;
        #1;
        exp_cnt = '0;
        checks++; if (noc3_valid_out !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 16'd0 || noc3_data_out !== 64'd0) begin
            errors++; $display("FAIL rmid_async got %b/%b/%h/%h want 0/0/0/0", noc3_valid_out, busy, pkt_cnt, noc3_data_out);
        end
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (noc3_valid_out !== 1'b0) begin errors++; $display("FAIL rmid_resume got %b want 0", noc3_valid_out); end
        tick;
        set_req(14'h0777, 8'h88, 8'h99, 26'h2222222, 6'h24, 64'h8000000000000001);
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_flit(k, 14'h0777, 8'h88, 8'h99, 26'h2222222, 6'h24, 64'h8000000000000001);
            checks++; if (noc3_valid_out !== 1'b1 || noc3_data_out !== e) begin
                errors++; $display("FAIL rmid_flit%0d got %b/%h want 1/%h", k, noc3_valid_out, noc3_data_out, e);
            end
            tick;
        end
        exp_cnt++;
        @(negedge clk);
        checks++; if (pkt_cnt !== exp_cnt) begin errors++; $display("FAIL rmid_cnt got %h want %h", pkt_cnt, exp_cnt); end
    endtask

    task automatic test_random;
        logic [65:0] q[$];
        logic [65:0] item;
        logic        stalled_prev;
        logic [63:0] prev_data;
        logic        exp_ready;
        stalled_prev = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick;
            if (cyc < 390) begin
                noc3_ready_in = ($urandom_range(0, 3) != 0);
                req_valid = ($urandom_range(0, 1) == 1);
                set_rand_req;
            end else begin
                noc3_ready_in = 1'b1;
                req_valid = 1'b0;
            end
            @(negedge clk);
            checks++; if (noc3_valid_out !== (q.size() != 0) || busy !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid cyc%0d got %b/%b want %b", cyc, noc3_valid_out, busy, (q.size() != 0));
            end
            exp_ready = (q.size() == 0) || (q.size() == 1 && noc3_ready_in);
            checks++; if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_ready cyc%0d got %b want %b", cyc, req_ready, exp_ready);
            end
            if (stalled_prev) begin
                checks++; if (noc3_data_out !== prev_data) begin
                    errors++; $display("FAIL rnd_hold cyc%0d got %h want %h", cyc, noc3_data_out, prev_data);
                end
            end
            if (!noc3_valid_out) begin
                checks++; if (noc3_data_out !== 64'd0) begin
                    errors++; $display("FAIL rnd_idle_data cyc%0d got %h want 0", cyc, noc3_data_out);
                end
            end
            if (noc3_valid_out && noc3_ready_in && q.size() != 0) begin
                item = q.pop_front();
                checks++; if (noc3_data_out !== item[63:0]) begin
                    errors++; $display("FAIL rnd_flit cyc%0d got %h want %h", cyc, noc3_data_out, item[63:0]);
                end
                if (item[65:64] == 2'd3) exp_cnt++;
            end
            stalled_prev = noc3_valid_out && !noc3_ready_in;
            prev_data = noc3_data_out;
            if (req_valid && req_ready) begin
                for (int k = 0; k < 4; k++)
                    q.push_back({2'(k), exp_flit(k, chipid, coreid_x, coreid_y, req_tag, req_source, req_data)});
            end
        end
        checks++; if (pkt_cnt !== exp_cnt || q.size() != 0) begin
            errors++; $display("FAIL rnd_end got cnt %h left %0d want cnt %h left 0", pkt_cnt, q.size(), exp_cnt);
        end
    endtask

    task automatic test_wrap;
        tick;
        force dut.pkt_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.pkt_cnt_q;
        exp_cnt = 16'hFFFE;
        #1;
        checks++; if (pkt_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_preload got %h want %h", pkt_cnt, exp_cnt); end
        noc3_ready_in = 1'b1;
        for (int p = 0; p < 2; p++) begin
            tick;
            set_rand_req;
            req_valid = 1'b1;
            tick;
            req_valid = 1'b0;
            repeat (4) tick;
            @(negedge clk);
            exp_cnt++;
            checks++; if (pkt_cnt !== exp_cnt || busy !== 1'b0) begin
                errors++; $display("FAIL wrap_pkt%0d got %h/%b want %h/0", p, pkt_cnt, busy, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_input_change;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
